pll_rst_seq: RTL
================

// Module: pll_rst_seq
// PURPOSE
//  Power-up/lock sequencer placed directly downstream of the board PLL wrapper.
//  Runs on the raw crystal clock. Drives the PLL's active-low POWERDOWN and
//  consumes its LOCK output. Holds the Wishbone-domain reset request until LOCK
//  has been continuously stable, re-powers the PLL on lock timeout, and latches
//  a fail flag after repeated failed lock attempts.
// PARAMETERS
//  PD_CYCLES    64     cycles the PLL is held powered down (pll_powerdown_n_o=0) per attempt
//  LOCK_STABLE  1024   consecutive cycles synchronised lock must stay high before releasing reset
//  LOCK_TIMEOUT 65536  cycles allowed in WAIT before a retry
//  MAX_RETRY    3      failed attempts (timeouts) before entering FAIL; range 1..15
//  CNT_W        17     cycle counter width; must satisfy 2**CNT_W >= max(PD_CYCLES, LOCK_STABLE, LOCK_TIMEOUT)
// PORTS
//  sys_clk_pad_i      in   1  crystal reference clock (same net that feeds the PLL CLKA)
//  rst_n_pad_i        in   1  asynchronous active-low reset
//  pll_lock_i         in   1  PLL LOCK, asynchronous to sys_clk_pad_i
//  pll_powerdown_n_o  out  1  to PLL POWERDOWN; 0 = PLL powered down
//  wb_rst_o           out  1  active-high reset request for the WB domain (resynchronised downstream)
//  pll_fail_o         out  1  sticky: retry budget exhausted
//  state_o            out  3  current FSM state, for debug
//  lock_loss_cnt_o    out  8  lock-loss counter (see CONFIGURATION)
// BEHAVIOUR
//  - pll_lock_i passes through a 2-flop synchroniser to lock_s; reset value 0.
//  - Reset (async, rst_n_pad_i=0):
//    - state=PD, cnt=0, retry=0.
//    - Outputs: pll_powerdown_n_o=0, wb_rst_o=1, pll_fail_o=0, lock_loss_cnt_o=0.
//  - All outputs are registered. Decode them from the next state so they change
//    on the same edge as the state.
//  - States (state_o encoding): PD=0, WAIT=1, STABLE=2, RUN=3, FAIL=4.
//  - PD: powerdown_n=0, wb_rst=1. Stay exactly PD_CYCLES cycles (cnt 0..PD_CYCLES-1),
//    then go to WAIT with cnt=0.
//  - WAIT: powerdown_n=1, wb_rst=1.
//    - lock_s=1: go to STABLE, cnt=0.
//    - Else, at cnt==LOCK_TIMEOUT-1: retry+1. If the new retry==MAX_RETRY, go to FAIL;
//      otherwise go to PD, cnt=0.
//  - STABLE: powerdown_n=1, wb_rst=1.
//    - lock_s=0: go to WAIT with cnt=0. The timeout window restarts.
//    - lock_s=1 and cnt==LOCK_STABLE-1: go to RUN, retry=0.
//    - STABLE therefore lasts exactly LOCK_STABLE cycles when lock holds.
//  - RUN: powerdown_n=1, wb_rst=0.
//    - lock_s=0: go to WAIT, cnt=0. wb_rst_o rises on that same edge (lock loss).
//  - FAIL: powerdown_n=0, wb_rst=1, pll_fail_o=1. Terminal; only rst_n_pad_i exits.
//  - Latency: lock_i rising (first sampling edge k), with lock held and state in WAIT:
//    STABLE at edge k+2, wb_rst_o low at edge k+2+LOCK_STABLE.
//  - Lock glitch of 1 cycle in STABLE: restarts the whole stable count via WAIT.
//    A glitch shorter than one cycle may be missed by the synchroniser; acceptable.
//  - cnt never wraps. It is compared against LOCK_TIMEOUT-1 and saturates implicitly
//    by the state change.
//  - Reset mid-operation: immediate return to reset values, including from FAIL and RUN.
// CONFIGURATION
//  PLL_RST_SEQ_LOCKLOSS_CNT_EN
//    - Defined: lock_loss_cnt_o increments by 1 on every RUN->WAIT transition.
//      8-bit, saturates at 255, cleared only by reset.
//    - Undefined: counter logic is absent; lock_loss_cnt_o is tied to 8'h00.
//    - FSM behaviour is identical either way.
// TESTING  (PD_CYCLES=4, LOCK_STABLE=16, LOCK_TIMEOUT=32, MAX_RETRY=2, CNT_W=6)
//  1. Reset release, lock_i=0 -> pll_powerdown_n_o=0 for 4 cycles, then 1; wb_rst_o stays 1.
//  2. In WAIT, lock_i 0->1 sampled at edge k and held -> state_o=2 at k+2;
//     wb_rst_o 1->0 at edge k+18; state_o=3.
//  3. In STABLE, lock_i low for 3 cycles at stable cnt=10, then high -> state_o returns 1
//     then 2; wb_rst_o releases 16 cycles after re-entering STABLE.
//  4. lock_i never rises -> timeout at 32 cycles, second PD (powerdown_n=0, 4 cycles),
//     second timeout -> state_o=4, pll_fail_o=1, pll_powerdown_n_o=0, held forever.
//  5. In RUN, lock_i drops -> wb_rst_o=1 within 3 edges; with _EN lock_loss_cnt_o=1,
//     without _EN 0. Force 300 losses -> saturates at 255.
//  6. rst_n_pad_i pulsed low mid-STABLE and while in FAIL -> all outputs return
//     immediately (async) to reset values; pll_fail_o clears.

Source files
------------

// File: rtl/pll_rst_seq.sv
// Power-up/lock sequencer for the board PLL: cycles POWERDOWN, qualifies LOCK and gates the WB-domain reset.
// Optional lock-loss counter is built when PLL_RST_SEQ_LOCKLOSS_CNT_EN is defined.
module pll_rst_seq #(
    parameter int PD_CYCLES    = 64,
    parameter int LOCK_STABLE  = 1024,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int MAX_RETRY    = 3,
    parameter int CNT_W        = 17
) (
    input  logic       sys_clk_pad_i,
    input  logic       rst_n_pad_i,
    input  logic       pll_lock_i,
    output logic       pll_powerdown_n_o,
    output logic       wb_rst_o,
    output logic       pll_fail_o,
    output logic [2:0] state_o,
    output logic [7:0] lock_loss_cnt_o
);

    typedef enum logic [2:0] {
        ST_PD     = 3'd0,
        ST_WAIT   = 3'd1,
        ST_STABLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_FAIL   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] PD_LAST      = CNT_W'(PD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRY);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       retry, retry_nxt;
    logic             lock_meta, lock_s;
    logic             powerdown_n_nxt, wb_rst_nxt, fail_nxt;

    // LOCK comes from the PLL's own analog loop, so it is asynchronous to the crystal clock.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sys_clk_pad_i or negedge rst_n_pad_i) begin
        if (!rst_n_pad_i) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock_i;
            lock_s    <= lock_meta;
        end
    end

    always_ff @(posedge sys_clk_pad_i or negedge rst_n_pad_i) begin
        if (!rst_n_pad_i) begin
            state <= ST_PD;
            cnt   <= '0;
            retry <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            retry <= retry_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        retry_nxt = retry;
        case (state)
            ST_PD: begin
                if (cnt == PD_LAST) begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            ST_WAIT: begin
                if (lock_s) begin
                    state_nxt = ST_STABLE;
                    cnt_nxt   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    retry_nxt = retry + 4'd1;
                    cnt_nxt   = '0;
                    state_nxt = (retry_nxt == RETRY_LIMIT) ? ST_FAIL : ST_PD;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            ST_STABLE: begin
                // Any dropout restarts qualification from WAIT with a fresh timeout window.
                if (!lock_s) begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = ST_RUN;
                    retry_nxt = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = '0;
                end
            end
            ST_FAIL: state_nxt = ST_FAIL;
            default: begin
                state_nxt = ST_PD;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Decoded from the next state so the registered outputs move on the same edge as state.
    always_comb begin
        powerdown_n_nxt = 1'b0;
        wb_rst_nxt      = 1'b1;
        fail_nxt        = 1'b0;
        case (state_nxt)
            ST_WAIT, ST_STABLE: powerdown_n_nxt = 1'b1;
            ST_RUN: begin
                powerdown_n_nxt = 1'b1;
                wb_rst_nxt      = 1'b0;
            end
            ST_FAIL: fail_nxt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk_pad_i or negedge rst_n_pad_i) begin
        if (!rst_n_pad_i) begin
            pll_powerdown_n_o <= 1'b0;
            wb_rst_o          <= 1'b1;
            pll_fail_o        <= 1'b0;
        end else begin
            pll_powerdown_n_o <= powerdown_n_nxt;
            wb_rst_o          <= wb_rst_nxt;
            pll_fail_o        <= fail_nxt;
        end
    end

    assign state_o = state;

`ifdef PLL_RST_SEQ_LOCKLOSS_CNT_EN
    logic [7:0] loss_cnt;

    // Counts RUN->WAIT transitions, saturating rather than wrapping.
    always_ff @(posedge sys_clk_pad_i or negedge rst_n_pad_i) begin
        if (!rst_n_pad_i) begin
            loss_cnt <= 8'h00;
        end else if (state == ST_RUN && state_nxt == ST_WAIT && loss_cnt != 8'hFF) begin
            loss_cnt <= loss_cnt + 8'd1;
        end
    end

    assign lock_loss_cnt_o = loss_cnt;
`else
    assign lock_loss_cnt_o = 8'h00;
`endif

endmodule
